mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
- Takes the EX/MEM outputs, performs the load/store on a data memory with variable latency over a req/ack handshake, and registers the result for the WB stage.
- Raises stall_o while an access is outstanding; hazard logic uses it to freeze PC, IF/ID, ID/EX and EX/MEM.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUSY cycles waiting for dmem_ack_i before the access is aborted (valid range 1..65535).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-low reset.
ALUresult_i  input  32  EX/MEM ALU result: memory address, or writeback value.
RS2data_i  input  32  EX/MEM store data.
RDaddr_i  input  5  EX/MEM destination register.
MemWrite_i  input  1  store.
MemRead_i  input  1  load.
MemtoReg_i  input  1  WB select.
RegWrite_i  input  1  WB register write enable.
dmem_req_o  output  1  memory request, registered.
dmem_we_o  output  1  1 = write, 0 = read; valid while req.
dmem_addr_o  output  32  latched address.
dmem_wdata_o  output  32  latched store data.
dmem_ack_i  input  1  access complete; rdata valid in the same cycle.
dmem_rdata_i  input  32  read data.
stall_o  output  1  combinational freeze request for upstream stages.
err_o  output  1  sticky timeout flag.
ALUresult_o  output  32  MEM/WB ALU result.
ReadData_o  output  32  MEM/WB load data.
RDaddr_o  output  5  MEM/WB destination register.
MemtoReg_o  output  1  MEM/WB control.
RegWrite_o  output  1  MEM/WB control.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, timeout counter=0, err_o=0, and every registered output=0 (dmem_*, ALUresult_o, ReadData_o, RDaddr_o, MemtoReg_o, RegWrite_o).
- Reset mid-access drops dmem_req_o immediately; the aborted instruction is lost.
- memop = MemRead_i | MemWrite_i. If both are 1, the op is treated as a write.
- stall_o = memop & ~(state==BUSY & (dmem_ack_i | timeout_hit)).
  - Purely combinational.
  - Upstream inputs are held stable while stall_o=1.
- IDLE, memop=0:
  - Pass-through; 1-cycle latency.
  - At the edge: ALUresult_o, RDaddr_o, MemtoReg_o, RegWrite_o <= inputs; ReadData_o <= 0.
- IDLE, memop=1:
  - At the edge: dmem_req_o<=1, dmem_we_o<=MemWrite_i, dmem_addr_o<=ALUresult_i, dmem_wdata_o<=RS2data_i, counter<=0, go to BUSY.
  - MEM/WB takes a bubble: RegWrite_o<=0, MemtoReg_o<=0, other outputs unchanged.
- BUSY, dmem_ack_i=0 and counter<TIMEOUT_CYCLES-1:
  - counter+1; hold request; bubble into MEM/WB.
- BUSY, dmem_ack_i=1:
  - stall_o=0 and upstream advances at this edge.
  - MEM/WB <= ALUresult_i, RDaddr_i, MemtoReg_i, RegWrite_i; ReadData_o <= dmem_rdata_i for a read, 0 for a write.
  - dmem_req_o<=0; go to IDLE.
  - Minimum load/store latency: 2 cycles (issue edge + ack edge).
- Timeout (timeout_hit = BUSY & ~ack & counter==TIMEOUT_CYCLES-1):
  - Completes exactly like ack but with ReadData_o<=0 and err_o<=1.
  - err_o stays set until reset.
- dmem_ack_i is ignored in IDLE.
- Back-to-back memops: the instruction after a completed access is re-evaluated in IDLE and issues on the next edge, so there is no request in the IDLE cycle.
- Counter is 16 bits and never wraps; it is cleared on every issue.

Test Plan:
- Pass-through: ALUresult_i=0x10, RDaddr_i=5, RegWrite_i=1, no memop -> next cycle ALUresult_o=0x10, RDaddr_o=5, RegWrite_o=1, stall_o=0 throughout.
- Load, ack 3 cycles after req: MemRead_i=1, ALUresult_i=0x40, dmem_rdata_i=0xDEADBEEF at ack -> dmem_addr_o=0x40, dmem_we_o=0; stall_o=1 for 4 cycles; ReadData_o=0xDEADBEEF and RegWrite_o=1 after the ack edge; RegWrite_o=0 during stall.
- Store, immediate ack: MemWrite_i=1, addr 0x80, RS2data_i=0x1234 -> dmem_we_o=1, dmem_wdata_o=0x1234; stall_o high 1 cycle; ReadData_o=0.
- Back-to-back: load then store, each acked on the first BUSY cycle -> two separate req pulses separated by one IDLE cycle; order preserved.
- Timeout with TIMEOUT_CYCLES=4 and ack never asserted -> after 4 BUSY cycles stall_o drops, ReadData_o=0, err_o=1; a subsequent normal load still completes and err_o stays 1.
- Reset mid-BUSY: rst_i=0 while req is high -> dmem_req_o, RegWrite_o, err_o go to 0 immediately; after release, state is IDLE and a new load completes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register.
// It issues loads and stores to a variable-latency data memory over req/ack, stalls upstream stages while an access is pending, and aborts the access on timeout.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUresult_i,
    input  logic [31:0] RS2data_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic [31:0] ALUresult_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RDaddr_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        m2r_q, m2r_d;
    logic        rw_q, rw_d;

    logic        memop_s;
    logic        busy_s;
    logic        timeout_hit_s;
    logic        done_s;

    // Access completion decode; a timeout counts as completion.
    always_comb begin
        memop_s       = MemRead_i | MemWrite_i;
        busy_s        = (state_q == S_BUSY);
        timeout_hit_s = busy_s & ~dmem_ack_i & (cnt_q == CNT_LAST);
        done_s        = busy_s & (dmem_ack_i | timeout_hit_s);
    end

    assign stall_o = memop_s & ~done_s;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (memop_s) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (done_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the memory interface, timeout counter and MEM/WB register.
    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        m2r_d   = m2r_q;
        rw_d    = rw_q;
        case (state_q)
            S_IDLE: begin
                if (memop_s) begin
                    // A load with MemWrite also set is treated as a store.
                    req_d   = 1'b1;
                    we_d    = MemWrite_i;
                    addr_d  = ALUresult_i;
                    wdata_d = RS2data_i;
                    cnt_d   = 16'd0;
                    rw_d    = 1'b0;
                    m2r_d   = 1'b0;
                end else begin
                    alu_d   = ALUresult_i;
                    rd_d    = RDaddr_i;
                    m2r_d   = MemtoReg_i;
                    rw_d    = RegWrite_i;
                    rdata_d = 32'd0;
                end
            end
            S_BUSY: begin
                if (done_s) begin
                    req_d = 1'b0;
                    alu_d = ALUresult_i;
                    rd_d  = RDaddr_i;
                    m2r_d = MemtoReg_i;
                    rw_d  = RegWrite_i;
                    err_d = err_q | timeout_hit_s;
                    if (dmem_ack_i && !we_q) begin
                        rdata_d = dmem_rdata_i;
                    end else begin
                        rdata_d = 32'd0;
                    end
                end else begin
                    rw_d  = 1'b0;
                    m2r_d = 1'b0;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            default: begin
                req_d = 1'b0;
                rw_d  = 1'b0;
                m2r_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            alu_q   <= 32'd0;
            rdata_q <= 32'd0;
            rd_q    <= 5'd0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            alu_q   <= alu_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            m2r_q   <= m2r_d;
            rw_q    <= rw_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign err_o        = err_q;
    assign ALUresult_o  = alu_q;
    assign ReadData_o   = rdata_q;
    assign RDaddr_o     = rd_q;
    assign MemtoReg_o   = m2r_q;
    assign RegWrite_o   = rw_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a transaction-level reference model is compared every cycle, with literal spot checks.
module tb_mem_wb_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] alu_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic [4:0]  rdad_i = 5'd0;
    logic        mw_i = 1'b0;
    logic        mr_i = 1'b0;
    logic        m2r_i = 1'b0;
    logic        rw_i = 1'b0;
    logic        ack_i = 1'b0;
    logic [31:0] rdata_i = 32'd0;

    logic        req_o, we_o, stall_o, err_o, m2r_o, rw_o;
    logic [31:0] addr_o, wdata_o, alu_o, rd_data_o;
    logic [4:0]  rdad_o;

    mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ALUresult_i(alu_i), .RS2data_i(rs2_i), .RDaddr_i(rdad_i),
        .MemWrite_i(mw_i), .MemRead_i(mr_i), .MemtoReg_i(m2r_i), .RegWrite_i(rw_i),
        .dmem_req_o(req_o), .dmem_we_o(we_o), .dmem_addr_o(addr_o), .dmem_wdata_o(wdata_o),
        .dmem_ack_i(ack_i), .dmem_rdata_i(rdata_i),
        .stall_o(stall_o), .err_o(err_o),
        .ALUresult_o(alu_o), .ReadData_o(rd_data_o), .RDaddr_o(rdad_o),
        .MemtoReg_o(m2r_o), .RegWrite_o(rw_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending access at a time, the number of cycles waited, and the expected outputs.
    logic        m_busy = 1'b0;
    int          m_wait = 0;
    logic        e_req = 1'b0, e_we = 1'b0, e_err = 1'b0, e_m2r = 1'b0, e_rw = 1'b0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_alu = 32'd0, e_rdata = 32'd0;
    logic [4:0]  e_rd = 5'd0;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_busy <= 1'b0; m_wait <= 0;
            e_req <= 1'b0; e_we <= 1'b0; e_err <= 1'b0; e_m2r <= 1'b0; e_rw <= 1'b0;
            e_addr <= 32'd0; e_wdata <= 32'd0; e_alu <= 32'd0; e_rdata <= 32'd0; e_rd <= 5'd0;
        end else if (!m_busy) begin
            if (mr_i || mw_i) begin
                m_busy <= 1'b1; m_wait <= 0;
                e_req <= 1'b1; e_we <= mw_i; e_addr <= alu_i; e_wdata <= rs2_i;
                e_rw <= 1'b0; e_m2r <= 1'b0;
            end else begin
                e_alu <= alu_i; e_rd <= rdad_i; e_m2r <= m2r_i; e_rw <= rw_i; e_rdata <= 32'd0;
            end
        end else if (ack_i || (m_wait == T - 1)) begin
            m_busy <= 1'b0; e_req <= 1'b0;
            e_alu <= alu_i; e_rd <= rdad_i; e_m2r <= m2r_i; e_rw <= rw_i;
            e_rdata <= (ack_i && !e_we) ? rdata_i : 32'd0;
            if (!ack_i) e_err <= 1'b1;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    // Compare all outputs against the model at every falling edge.
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = (mr_i | mw_i) & ~(m_busy & (ack_i | (m_wait == T - 1)));
        chk("stall", stall_o, exp_stall);
        chk("req", req_o, e_req);
        chk("we", we_o, e_req ? e_we : we_o);
        chk("addr", addr_o, e_req ? e_addr : addr_o);
        chk("wdata", wdata_o, (e_req && e_we) ? e_wdata : wdata_o);
        chk("err", err_o, e_err);
        chk("alu", alu_o, e_alu);
        chk("rdata", rd_data_o, e_rdata);
        chk("rd", rdad_o, e_rd);
        chk("m2r", m2r_o, e_m2r);
        chk("rw", rw_o, e_rw);
    end

    int   n_stall = 0;
    int   n_rise = 0;
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (stall_o) n_stall <= n_stall + 1;
        if (req_o && !prev_req) n_rise <= n_rise + 1;
        prev_req <= req_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        alu_i = 32'd0; rs2_i = 32'd0; rdad_i = 5'd0;
        mw_i = 1'b0; mr_i = 1'b0; m2r_i = 1'b0; rw_i = 1'b0; ack_i = 1'b0;
    endtask

    task automatic pass(input logic [31:0] a, input logic [4:0] rd, input logic m2r,
                        input logic rw, input logic noise_ack);
        set_nop();
        alu_i = a; rdad_i = rd; m2r_i = m2r; rw_i = rw;
        ack_i = noise_ack; rdata_i = 32'hFFFF_FFFF;
        step();
        ack_i = 1'b0;
    endtask

    // Issue one access and hold it; ack_at=0 means the memory never answers.
    task automatic mem(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rdad, input logic m2r, input logic rw,
                       input int ack_at, input logic [31:0] rdat);
        int n;
        set_nop();
        mr_i = rd; mw_i = wr; alu_i = a; rs2_i = wd; rdad_i = rdad; m2r_i = m2r; rw_i = rw;
        rdata_i = 32'h5555_5555;
        step();
        n = (ack_at > 0) ? ack_at : T;
        for (int k = 1; k <= n; k++) begin
            if (k == ack_at) begin
                ack_i = 1'b1;
                rdata_i = rdat;
            end
            step();
            ack_i = 1'b0;
        end
        set_nop();
    endtask

    int s0;
    int r0;

    initial begin
        #2;
        chk("rst_req", req_o, 1'b0);
        chk("rst_rw", rw_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_alu", alu_o, 32'd0);
        step();
        step();
        rst_i = 1'b1;

        pass(32'h10, 5'd5, 1'b0, 1'b1, 1'b1);
        chk("pt_alu", alu_o, 32'h10);
        chk("pt_rd", rdad_o, 5'd5);
        chk("pt_rw", rw_o, 1'b1);
        chk("pt_rdata", rd_data_o, 32'd0);

        s0 = n_stall;
        mem(1'b1, 1'b0, 32'h40, 32'd0, 5'd7, 1'b1, 1'b1, 4, 32'hDEAD_BEEF);
        chk("ld_rdata", rd_data_o, 32'hDEAD_BEEF);
        chk("ld_rw", rw_o, 1'b1);
        chk("ld_addr", addr_o, 32'h40);
        chk("ld_we", we_o, 1'b0);
        chk("ld_stalls", n_stall - s0, 4);

        s0 = n_stall;
        mem(1'b0, 1'b1, 32'h80, 32'h1234, 5'd0, 1'b0, 1'b0, 1, 32'h7777_7777);
        chk("st_rdata", rd_data_o, 32'd0);
        chk("st_we", we_o, 1'b1);
        chk("st_wdata", wdata_o, 32'h1234);
        chk("st_stalls", n_stall - s0, 1);

        r0 = n_rise;
        mem(1'b1, 1'b0, 32'hC0, 32'd0, 5'd3, 1'b1, 1'b1, 1, 32'hA5A5_A5A5);
        chk("b2b_ld_rdata", rd_data_o, 32'hA5A5_A5A5);
        chk("b2b_ld_rd", rdad_o, 5'd3);
        mem(1'b0, 1'b1, 32'hC4, 32'h99, 5'd4, 1'b0, 1'b0, 1, 32'h1111_1111);
        chk("b2b_st_rd", rdad_o, 5'd4);
        chk("b2b_st_rdata", rd_data_o, 32'd0);
        chk("b2b_pulses", n_rise - r0, 2);

        s0 = n_stall;
        mem(1'b1, 1'b0, 32'h100, 32'd0, 5'd9, 1'b1, 1'b1, 0, 32'd0);
        chk("to_err", err_o, 1'b1);
        chk("to_rdata", rd_data_o, 32'd0);
        chk("to_rw", rw_o, 1'b1);
        chk("to_stalls", n_stall - s0, 4);
        mem(1'b1, 1'b0, 32'h104, 32'd0, 5'd10, 1'b1, 1'b1, 2, 32'h0BAD_F00D);
        chk("post_to_rdata", rd_data_o, 32'h0BAD_F00D);
        chk("post_to_err", err_o, 1'b1);

        set_nop();
        mr_i = 1'b1; alu_i = 32'h200; rdad_i = 5'd11; m2r_i = 1'b1; rw_i = 1'b1;
        step();
        step();
        chk("mid_req_pre", req_o, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mid_req", req_o, 1'b0);
        chk("mid_rw", rw_o, 1'b0);
        chk("mid_err", err_o, 1'b0);
        set_nop();
        step();
        rst_i = 1'b1;
        mem(1'b1, 1'b0, 32'h204, 32'd0, 5'd12, 1'b1, 1'b1, 1, 32'h600D_CAFE);
        chk("post_rst_rdata", rd_data_o, 32'h600D_CAFE);
        chk("post_rst_rd", rdad_o, 5'd12);
        chk("post_rst_err", err_o, 1'b0);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
